// File: rtl/comb_code_pkg.sv
// Shared definitions for the code-word inverter slice.
//   encode()  : the one golden definition of the forward equations
//               F1 = xz ^ x'y'z', F2 = x'y ^ xy'z', F3 = xy ^ x'y'z'
//   state_t   : FSM state encoding (IDLE / EMIT / NONE)
//   *_BIT     : bit positions of F1..F3 in a code word and x..z in a candidate
package comb_code_pkg;

  typedef logic [2:0] code_t;  // {F1,F2,F3}
  typedef logic [2:0] xyz_t;   // {x,y,z}

  localparam int F1_BIT = 2;
  localparam int F2_BIT = 1;
  localparam int F3_BIT = 0;
  localparam int X_BIT  = 2;
  localparam int Y_BIT  = 1;
  localparam int Z_BIT  = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    NONE = 2'd2
  } state_t;

  function automatic code_t encode(input xyz_t xyz);
    logic x, y, z;
    code_t f;
    x = xyz[X_BIT];
    y = xyz[Y_BIT];
    z = xyz[Z_BIT];
    f         = '0;
    f[F1_BIT] = (x & z) ^ (~x & ~y & ~z);
    f[F2_BIT] = (~x & y) ^ (x & ~y & ~z);
    f[F3_BIT] = (x & y) ^ (~x & ~y & ~z);
    return f;
  endfunction

endpackage

// File: rtl/comb_code_inverter_if.sv
// Handshake bundle between a code-word source/sink and the inverter.
//   in_valid/in_ready/in_code            : code word request channel
//   out_valid/out_ready/out_xyz/
//   out_last/out_none                    : candidate response stream
// master = the environment, slave = the inverter.
interface comb_code_inverter_if;
  import comb_code_pkg::*;

  logic  in_valid;
  logic  in_ready;
  code_t in_code;
  logic  out_valid;
  logic  out_ready;
  xyz_t  out_xyz;
  logic  out_last;
  logic  out_none;

  modport master (
    output in_valid, in_code, out_ready,
    input  in_ready, out_valid, out_xyz, out_last, out_none
  );

  modport slave (
    input  in_valid, in_code, out_ready,
    output in_ready, out_valid, out_xyz, out_last, out_none
  );

endinterface

// File: rtl/comb_code_preimage.sv
// Purely combinational preimage finder.
//   code : {F1,F2,F3} code word
//   mask : mask[i] = 1 when candidate i (as {x,y,z}) encodes to code
module comb_code_preimage
  import comb_code_pkg::*;
(
  input  code_t      code,
  output logic [7:0] mask
);

  for (genvar i = 0; i < 8; i++) begin : g_cand
    assign mask[i] = (encode(3'(i)) == code);
  end

endmodule

// File: rtl/comb_code_inverter.sv
// Decoder for the 3-in/3-out encoder: accepts one code word and streams
// every {x,y,z} mapping to it in ascending order, or one flagged beat when
// the code has no preimage.
//   clk       : rising-edge clock
//   rst       : synchronous reset, active-high
//   bus       : request/response handshake bundle (slave side)
//   err_count : saturating count of no-preimage responses delivered
//   busy      : a response is pending (state != IDLE)
module comb_code_inverter
  import comb_code_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  comb_code_inverter_if.slave  bus,
  output logic [CNT_W-1:0]     err_count,
  output logic                 busy
);

  state_t           state, state_nxt;
  logic [7:0]       mask, mask_nxt;
  logic [7:0]       code_mask;
  logic [CNT_W-1:0] err_nxt;
  xyz_t             low_idx;
  logic             only_one;

  comb_code_preimage u_preimage (
    .code (bus.in_code),
    .mask (code_mask)
  );

  // Lowest set bit of the pending mask: scan downward so the lowest wins.
  always_comb begin
    low_idx = '0;
    for (int i = 7; i >= 0; i--) begin
      if (mask[i]) low_idx = 3'(i);
    end
  end

  // Exactly one candidate left: clearing the lowest bit empties the mask.
  assign only_one = ((mask & (mask - 8'd1)) == 8'd0);

  // NOTE: every signal written here gets a default first, so no path through
  // the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_nxt     = state;
    mask_nxt      = mask;
    err_nxt       = err_count;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.out_xyz   = '0;
    bus.out_last  = 1'b0;
    bus.out_none  = 1'b0;

    case (state)
      IDLE: begin
        bus.in_ready = ~rst;
        if (bus.in_valid && !rst) begin
          mask_nxt  = code_mask;
          state_nxt = (code_mask != 8'd0) ? EMIT : NONE;
        end
      end

      EMIT: begin
        bus.out_valid = 1'b1;
        bus.out_xyz   = low_idx;
        bus.out_last  = only_one;
        if (bus.out_ready) begin
          mask_nxt = mask & (mask - 8'd1);
          if (only_one) state_nxt = IDLE;
        end
      end

      NONE: begin
        bus.out_valid = 1'b1;
        bus.out_last  = 1'b1;
        bus.out_none  = 1'b1;
        if (bus.out_ready) begin
          err_nxt   = (&err_count) ? err_count : err_count + CNT_W'(1);
          state_nxt = IDLE;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      mask      <= '0;
      err_count <= '0;
    end else begin
      state     <= state_nxt;
      mask      <= mask_nxt;
      err_count <= err_nxt;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_comb_code_inverter.sv
// Self-checking bench: two inverters (CNT_W=8 and CNT_W=2) see identical
// traffic; a queue-based response model is compared every cycle, and
// directed tests pin beat sequences and timing with literal values.
module tb_comb_code_inverter;

  typedef struct packed {
    logic [2:0] xyz;
    logic       last;
    logic       none;
  } beat_t;

  typedef struct packed {
    beat_t       b;
    logic [31:0] cyc;
  } rec_t;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [2:0] in_code;
  logic       out_ready;
  logic [7:0] err8;
  logic [1:0] err2;
  logic       busy8, busy2;

  comb_code_inverter_if if8 ();
  comb_code_inverter_if if2 ();

  assign if8.in_valid  = in_valid;
  assign if8.in_code   = in_code;
  assign if8.out_ready = out_ready;
  assign if2.in_valid  = in_valid;
  assign if2.in_code   = in_code;
  assign if2.out_ready = out_ready;

  comb_code_inverter #(.CNT_W(8)) dut8 (
    .clk       (clk),
    .rst       (rst),
    .bus       (if8.slave),
    .err_count (err8),
    .busy      (busy8)
  );

  comb_code_inverter #(.CNT_W(2)) dut2 (
    .clk       (clk),
    .rst       (rst),
    .bus       (if2.slave),
    .err_count (err2),
    .busy      (busy2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Forward equations written straight from the boolean definitions.
  function automatic logic [2:0] model_enc(input int v);
    logic x, y, z;
    x = v[2]; y = v[1]; z = v[0];
    return {(x & z) ^ (!x & !y & !z), (!x & y) ^ (x & !y & !z), (x & y) ^ (!x & !y & !z)};
  endfunction

  // ---------------- response model ----------------
  beat_t      q[$];
  logic [7:0] m_err8;
  logic [1:0] m_err2;
  beat_t      nb;
  int         m_cnt, m_k;

  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      m_err8 = 0;
      m_err2 = 0;
    end else if (q.size() != 0) begin
      if (out_ready) begin
        nb = q.pop_front();
        if (nb.none) begin
          if (m_err8 != 8'hff) m_err8 = m_err8 + 1;
          if (m_err2 != 2'h3)  m_err2 = m_err2 + 1;
        end
      end
    end else if (in_valid) begin
      m_cnt = 0;
      for (int i = 0; i < 8; i++) if (model_enc(i) == in_code) m_cnt++;
      if (m_cnt == 0) begin
        nb = {3'd0, 1'b1, 1'b1};
        q.push_back(nb);
      end else begin
        m_k = 0;
        for (int i = 0; i < 8; i++) begin
          if (model_enc(i) == in_code) begin
            m_k++;
            nb = {3'(i), (m_k == m_cnt), 1'b0};
            q.push_back(nb);
          end
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  logic cmp_en = 1'b0;

  always @(negedge clk) begin
    if (cmp_en) begin
      check("in_ready8",  if8.in_ready,  (q.size() == 0) && !rst);
      check("in_ready2",  if2.in_ready,  (q.size() == 0) && !rst);
      check("out_valid8", if8.out_valid, q.size() != 0);
      check("out_valid2", if2.out_valid, q.size() != 0);
      check("busy8",      busy8,         q.size() != 0);
      check("busy2",      busy2,         q.size() != 0);
      check("err8",       err8,          m_err8);
      check("err2",       err2,          m_err2);
      if (q.size() != 0) begin
        check("beat8", {if8.out_xyz, if8.out_last, if8.out_none}, q[0]);
        check("beat2", {if2.out_xyz, if2.out_last, if2.out_none}, q[0]);
      end
    end
  end

  // ---------------- handshake collector (dut8) ----------------
  rec_t        got[$];
  logic [31:0] cyc = 0;
  logic [31:0] last_acc = 0;
  logic        s_valid, s_ready;
  beat_t       s_beat;

  always @(negedge clk) begin
    s_valid = if8.out_valid;
    s_ready = if8.in_ready;
    s_beat  = {if8.out_xyz, if8.out_last, if8.out_none};
  end

  always @(posedge clk) begin
    if (rst === 1'b0) begin
      if (s_valid === 1'b1 && out_ready) got.push_back({s_beat, cyc});
      if (s_ready === 1'b1 && in_valid)  last_acc = cyc;
    end
    cyc = cyc + 1;
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic send_code(input logic [2:0] code, input bit hold);
    bit acc;
    acc      = 0;
    in_code  = code;
    in_valid = 1'b1;
    for (int k = 0; k < 40 && !acc; k++) begin
      @(negedge clk);
      if (if8.in_ready === 1'b1) acc = 1;
      step();
    end
    if (!acc) check("accept_timeout", 0, 1);
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 60 && q.size() != 0; k++) step();
    if (q.size() != 0) check("drain_timeout", 0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  logic [7:0]  exp_mask, got_mask;
  logic [31:0] acc_before;
  int          total_beats;

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_code   = 3'd0;
    out_ready = 1'b1;

    // ---- reset ----
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", if8.in_ready, 0);
    step();
    rst    = 1'b0;
    cmp_en = 1'b1;
    @(negedge clk);
    check("rst_out_valid", if8.out_valid, 0);
    check("rst_busy",      busy8, 0);
    check("rst_err",       err8, 0);
    check("rst_beat",      {if8.out_xyz, if8.out_last, if8.out_none}, 5'b0);
    check("rst_ready_up",  if8.in_ready, 1);
    step();

    // ---- decode 010, out_ready=1 ----
    got.delete();
    send_code(3'b010, 0);
    drain();
    check("t1_count", got.size(), 3);
    if (got.size() == 3) begin
      check("t1_b0", got[0].b, {3'b010, 1'b0, 1'b0});
      check("t1_b1", got[1].b, {3'b011, 1'b0, 1'b0});
      check("t1_b2", got[2].b, {3'b100, 1'b1, 1'b0});
      for (int i = 0; i < 3; i++)
        check($sformatf("t1_cyc%0d", i), got[i].cyc, last_acc + 1 + i);
    end
    @(negedge clk);
    check("t1_ready_back", if8.in_ready, 1);
    step();

    // ---- 101 then 000 back-to-back ----
    got.delete();
    send_code(3'b101, 1);
    send_code(3'b000, 0);
    drain();
    check("t2_count", got.size(), 3);
    if (got.size() == 3) begin
      check("t2_b0", got[0].b, {3'b000, 1'b0, 1'b0});
      check("t2_b1", got[1].b, {3'b111, 1'b1, 1'b0});
      check("t2_b2", got[2].b, {3'b001, 1'b1, 1'b0});
      check("t2_acc_after_last", last_acc, got[1].cyc + 1);
    end

    // ---- 111: no preimage, counters ----
    got.delete();
    send_code(3'b111, 0);
    drain();
    check("t3_count", got.size(), 1);
    if (got.size() == 1) check("t3_beat", got[0].b, {3'b000, 1'b1, 1'b1});
    @(negedge clk);
    check("t3_err8_one", err8, 1);
    check("t3_err2_one", err2, 1);
    step();
    repeat (5) begin
      send_code(3'b111, 0);
      drain();
    end
    @(negedge clk);
    check("t3_err8_six", err8, 6);
    check("t3_err2_sat", err2, 3);
    step();

    // ---- backpressure on 010 ----
    out_ready = 1'b0;
    got.delete();
    send_code(3'b010, 0);
    acc_before = last_acc;
    in_valid   = 1'b1;
    in_code    = 3'b100;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t4_hold_xyz",   if8.out_xyz, 3'b010);
      check("t4_hold_valid", if8.out_valid, 1);
      check("t4_no_ready",   if8.in_ready, 0);
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drain();
    check("t4_no_accept", last_acc, acc_before);
    check("t4_count", got.size(), 3);
    if (got.size() == 3) begin
      check("t4_b0", got[0].b.xyz, 3'b010);
      check("t4_b1", got[1].b.xyz, 3'b011);
      check("t4_b2", got[2].b.xyz, 3'b100);
    end

    // ---- reset mid-EMIT ----
    got.delete();
    send_code(3'b010, 0);
    step();            // beat 010 handshakes here
    rst = 1'b1;
    step();            // reset edge
    rst = 1'b0;
    @(negedge clk);
    check("t5_out_valid", if8.out_valid, 0);
    check("t5_busy",      busy8, 0);
    check("t5_err8",      err8, 0);
    check("t5_err2",      err2, 0);
    check("t5_count",     got.size(), 1);
    if (got.size() == 1) check("t5_b0", got[0].b.xyz, 3'b010);
    step();
    got.delete();
    send_code(3'b100, 0);
    drain();
    check("t5_fresh_count", got.size(), 1);
    if (got.size() == 1) check("t5_fresh_beat", got[0].b, {3'b101, 1'b1, 1'b0});

    // ---- exhaustive ----
    total_beats = 0;
    for (int c = 0; c < 8; c++) begin
      got.delete();
      send_code(3'(c), 0);
      drain();
      exp_mask = '0;
      for (int i = 0; i < 8; i++) if (model_enc(i) == 3'(c)) exp_mask[i] = 1'b1;
      got_mask = '0;
      foreach (got[j]) if (!got[j].b.none) got_mask[got[j].b.xyz] = 1'b1;
      check($sformatf("t6_mask_code%0d", c), got_mask, exp_mask);
      total_beats += got.size();
    end
    check("t6_total_beats", total_beats, 11);
    @(negedge clk);
    check("t6_err8", err8, 3);
    check("t6_err2", err2, 3);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
